// File: rtl/tt_add_seq_pkg.sv
// Shared types and pin map for the time-shared 8-bit accumulate sequencer.
package tt_add_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    // uio_in bit positions
    localparam int unsigned STRB  = 0;
    localparam int unsigned START = 1;
    localparam int unsigned ACK   = 2;

    // uio_out bit positions
    localparam int unsigned BUSY  = 7;
    localparam int unsigned DONE  = 6;
    localparam int unsigned CARRY = 5;

    // ui_in bit that selects saturating mode in the start command word
    localparam int unsigned SAT_BIT = 4;

    localparam logic [7:0] UIO_OE_VAL = 8'hE0;

endpackage

// File: rtl/sync_edge.sv
// Pin synchronizer followed by a rising-edge detector; pulse is one clock wide.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/tt_um_add_sequencer.sv
// TinyTapeout top: accumulates a programmed number of strobed operands through one 8-bit adder,
// with sticky carry, optional saturation and busy/done handshake on the bidirectional pins.
module tt_um_add_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    import tt_add_seq_pkg::*;

    localparam int unsigned REM_W = CNT_W + 1;
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    logic strb_p, start_p, ack_p;

    state_e           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             sat_q, sat_d;
    logic [8:0]       sum9;

    // Upper uio_in bits carry no function.
    logic unused_uio;
    assign unused_uio = ^uio_in[7:3];

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strb (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in[STRB]),
        .pulse (strb_p)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in[START]),
        .pulse (start_p)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in[ACK]),
        .pulse (ack_p)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        sum9    = {1'b0, acc_q} + {1'b0, ui_in};

        // start wins over a coincident strb or ack; that strb's data is dropped.
        if (start_p) begin
            acc_d   = '0;
            carry_d = 1'b0;
            sat_d   = ui_in[SAT_BIT];
            state_d = StAccum;
            if (ui_in[CNT_W-1:0] == '0) begin
                rem_d = {1'b1, {CNT_W{1'b0}}};
            end else begin
                rem_d = {1'b0, ui_in[CNT_W-1:0]};
            end
        end else begin
            case (state_q)
                StAccum: begin
                    if (strb_p) begin
                        acc_d   = (sat_q && sum9[8]) ? 8'hFF : sum9[7:0];
                        carry_d = carry_q | sum9[8];
                        rem_d   = rem_q - REM_ONE;
                        if (rem_q == REM_ONE) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (ack_p) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        uio_out        = '0;
        uio_out[BUSY]  = (state_q == StAccum);
        uio_out[DONE]  = (state_q == StDone);
        uio_out[CARRY] = carry_q;
    end

    assign uo_out = acc_q;
    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_add_sequencer.sv
// Directed, table-driven bench for tt_um_add_sequencer plus hand sequences for reset/enable/races.
module tb_tt_um_add_sequencer;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 4;

    localparam logic [7:0] M_STRB  = 8'h01;
    localparam logic [7:0] M_START = 8'h02;
    localparam logic [7:0] M_ACK   = 8'h04;

    localparam logic [7:0] S_BUSY  = 8'h80;
    localparam logic [7:0] S_DONE  = 8'h40;
    localparam logic [7:0] S_CARRY = 8'h20;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] data;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] prev_uo = '0;
    vec_t vecs[$];

    tt_um_add_sequencer #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] mask, input logic [7:0] data,
                           input logic [7:0] exp_uo, input logic [7:0] exp_uio);
        vec_t v;
        v.mask = mask;
        v.data = data;
        v.exp_uo = exp_uo;
        v.exp_uio = exp_uio;
        vecs.push_back(v);
    endtask

    // Raise the pin(s), hold ui_in until the registering edge, then release and let it settle.
    task automatic apply(input logic [7:0] mask, input logic [7:0] data,
                         input logic [7:0] exp_uo, input logic [7:0] exp_uio, input string name);
        @(negedge clk);
        ui_in  = data;
        uio_in = mask;
        repeat (SYNC_STAGES) @(posedge clk);
        #1 check({name, "_early"}, uo_out, prev_uo);
        @(posedge clk);
        #1;
        check({name, "_uo"}, uo_out, exp_uo);
        check({name, "_uio"}, uio_out, exp_uio);
        prev_uo = exp_uo;
        @(negedge clk);
        uio_in = '0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
    endtask

    initial begin
        // Basic accumulate, then ack
        add_vec(M_START, 8'h03, 8'd0, S_BUSY);
        add_vec(M_STRB, 8'd10, 8'd10, S_BUSY);
        add_vec(M_STRB, 8'd20, 8'd30, S_BUSY);
        add_vec(M_STRB, 8'd30, 8'd60, S_DONE);
        add_vec(M_ACK, 8'h00, 8'd60, 8'h00);
        // Wrap
        add_vec(M_START, 8'h02, 8'd0, S_BUSY);
        add_vec(M_STRB, 8'd200, 8'd200, S_BUSY);
        add_vec(M_STRB, 8'd100, 8'd44, S_DONE | S_CARRY);
        // Saturate
        add_vec(M_START, 8'h12, 8'd0, S_BUSY);
        add_vec(M_STRB, 8'd200, 8'd200, S_BUSY);
        add_vec(M_STRB, 8'd100, 8'd255, S_DONE | S_CARRY);
        add_vec(M_START, 8'h13, 8'd0, S_BUSY);
        add_vec(M_STRB, 8'd5, 8'd5, S_BUSY);
        add_vec(M_STRB, 8'd250, 8'd255, S_BUSY);
        add_vec(M_STRB, 8'd7, 8'd255, S_DONE | S_CARRY);
        // strb ignored in DONE and IDLE; carry survives ack
        add_vec(M_STRB, 8'd9, 8'd255, S_DONE | S_CARRY);
        add_vec(M_ACK, 8'h00, 8'd255, S_CARRY);
        add_vec(M_STRB, 8'd1, 8'd255, S_CARRY);
        // Count 0 means sixteen operands
        add_vec(M_START, 8'h00, 8'd0, S_BUSY);
        for (int k = 1; k <= 15; k++) begin
            add_vec(M_STRB, 8'd16, 8'(16 * k), S_BUSY);
        end
        add_vec(M_STRB, 8'd16, 8'd0, S_DONE | S_CARRY);
        // Restart mid-ACCUM clears carry and reloads the count; ack in ACCUM ignored
        add_vec(M_START, 8'h03, 8'd0, S_BUSY);
        add_vec(M_STRB, 8'd200, 8'd200, S_BUSY);
        add_vec(M_ACK, 8'h00, 8'd200, S_BUSY);
        add_vec(M_STRB, 8'd100, 8'd44, S_BUSY | S_CARRY);
        add_vec(M_START, 8'h03, 8'd0, S_BUSY);
        add_vec(M_STRB, 8'd1, 8'd1, S_BUSY);
        add_vec(M_STRB, 8'd2, 8'd3, S_BUSY);
        add_vec(M_STRB, 8'd3, 8'd6, S_DONE);

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_uo", uo_out, 8'h00);
        check("por_uio", uio_out, 8'h00);
        check("por_oe", uio_oe, 8'hE0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i].mask, vecs[i].data, vecs[i].exp_uo, vecs[i].exp_uio,
                  $sformatf("vec%0d", i));
        end

        // start and strb rise together: strb data must not be accumulated
        apply(M_START | M_STRB, 8'h02, 8'd0, S_BUSY, "race_start");
        apply(M_STRB, 8'd5, 8'd5, S_BUSY, "race_op1");
        apply(M_STRB, 8'd6, 8'd11, S_DONE, "race_op2");

        // Reset for one edge mid-ACCUM
        apply(M_START, 8'h03, 8'd0, S_BUSY, "rst_start");
        apply(M_STRB, 8'd10, 8'd10, S_BUSY, "rst_op");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'hE0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_uo = 8'h00;
        apply(M_STRB, 8'd5, 8'd0, 8'h00, "rst_idle_strb");

        // Strobe while disabled is lost for good
        apply(M_START, 8'h03, 8'd0, S_BUSY, "ena_start");
        apply(M_STRB, 8'd4, 8'd4, S_BUSY, "ena_op1");
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'd9;
        uio_in = M_STRB;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1 check("ena_off_uo", uo_out, 8'd4);
        @(negedge clk);
        uio_in = '0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        @(negedge clk);
        ena = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
        check("ena_on_uo", uo_out, 8'd4);
        check("ena_on_uio", uio_out, S_BUSY);
        apply(M_STRB, 8'd1, 8'd5, S_BUSY, "ena_op2");
        apply(M_STRB, 8'd2, 8'd7, S_DONE, "ena_op3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
